// File: rtl/rival_pkg.sv
// Shared types, constants and helpers for the rival-car fleet.
package rival_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      CRASH = 2'd1
   } state_e;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   // Right-shift Fibonacci form of taps 16,14,13,11: feedback from bits 0,2,3,5.
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

   function automatic logic [15:0] lfsr_next(input logic [15:0] lfsr);
      return {^(lfsr & LFSR_TAPS), lfsr[15:1]};
   endfunction

   function automatic logic overlap(
      input logic [31:0] rx,
      input logic [31:0] ry,
      input logic [31:0] px,
      input logic [31:0] py,
      input logic [31:0] w,
      input logic [31:0] h
   );
      return (rx < px + w) && (px < rx + w) && (ry < py + h) && (py < ry + h);
   endfunction

endpackage

// File: rtl/rival_slot.sv
// One rival car: holds active/x/y, moves down on each run tick, flags
// when it leaves the screen and when it overlaps the player box.
module rival_slot
   import rival_pkg::*;
#(
   parameter int X_W      = 10,
   parameter int Y_W      = 10,
   parameter int CAR_W    = 32,
   parameter int CAR_H    = 64,
   parameter int SCREEN_H = 480
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_move,
   input  logic           i_freeze,
   input  logic           i_spawn,
   input  logic [X_W-1:0] i_spawn_x,
   input  logic [3:0]     i_speed,
   input  logic [X_W-1:0] i_px,
   input  logic [Y_W-1:0] i_py,
   output logic           o_active,
   output logic [X_W-1:0] o_x,
   output logic [Y_W-1:0] o_y,
   output logic           o_exit,
   output logic           o_overlap
);

   logic           r_active;
   logic [X_W-1:0] r_x;
   logic [Y_W-1:0] r_y;

   logic [Y_W:0]   w_y_sum;
   logic           w_off_screen;

   assign w_y_sum      = {1'b0, r_y} + (Y_W+1)'(i_speed);
   assign w_off_screen = (w_y_sum >= (Y_W+1)'(SCREEN_H));

   assign o_exit    = r_active & i_move & ~i_freeze & w_off_screen;
   assign o_overlap = r_active & overlap(32'(r_x), 32'(r_y), 32'(i_px), 32'(i_py),
                                         32'(CAR_W), 32'(CAR_H));

   assign o_active = r_active;
   assign o_x      = r_x;
   assign o_y      = r_y;

   // A spawn wins over the exit of the same tick so a freed slot refills at once.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_active <= 1'b0;
         r_x      <= '0;
         r_y      <= '0;
      end else if (!i_freeze) begin
         if (i_spawn) begin
            r_active <= 1'b1;
            r_x      <= i_spawn_x;
            r_y      <= '0;
         end else if (i_move && r_active) begin
            if (w_off_screen) begin
               r_active <= 1'b0;
               r_x      <= '0;
               r_y      <= '0;
            end else begin
               r_y <= w_y_sum[Y_W-1:0];
            end
         end
      end
   end

endmodule

// File: rtl/rival_fleet.sv
// Rival-car fleet: game FSM, spawn LFSR and timer, free-slot picker,
// score and speed level around N_RIVALS generated rival_slot instances.
//
//   state | meaning
//   RUN   | rivals move/spawn/score on tick; any overlap moves to CRASH
//   CRASH | everything frozen, ticks ignored; left only through BTNC
module rival_fleet
   import rival_pkg::*;
#(
   parameter int N_RIVALS   = 4,
   parameter int N_LANES    = 4,
   parameter int X_W        = 10,
   parameter int Y_W        = 10,
   parameter int CAR_W      = 32,
   parameter int CAR_H      = 64,
   parameter int SCREEN_H   = 480,
   parameter int LANE_X0    = 160,
   parameter int LANE_PITCH = 80,
   parameter int SPAWN_GAP  = 90,
   parameter int LEVEL_PTS  = 8,
   parameter int SPEED_MAX  = 8
) (
   input  logic                    clk,
   input  logic                    BTNC,
   input  logic                    tick,
   input  logic [X_W-1:0]          car_x,
   input  logic [Y_W-1:0]          car_y,
   output logic [N_RIVALS*X_W-1:0] rival_x,
   output logic [N_RIVALS*Y_W-1:0] rival_y,
   output logic [N_RIVALS-1:0]     rival_active,
   output logic                    collision,
   output logic [1:0]              game_state,
   output logic [15:0]             score,
   output logic [3:0]              speed
);

   localparam int LANE_BITS = $clog2(N_LANES);
   localparam int CNT_W     = $clog2(SPAWN_GAP + 1);

   state_e               r_state;
   state_e               w_state_next;
   logic [15:0]          r_lfsr;
   logic [CNT_W-1:0]     r_spawn_cnt;
   logic [CNT_W-1:0]     w_spawn_cnt_next;
   logic [15:0]          r_score;
   logic [15:0]          w_score_next;
   logic [3:0]           r_speed;
   logic [3:0]           w_speed_next;

   logic [N_RIVALS-1:0]  w_active;
   logic [N_RIVALS-1:0]  w_exit;
   logic [N_RIVALS-1:0]  w_overlap;
   logic [N_RIVALS-1:0]  w_free;
   logic [N_RIVALS-1:0]  w_spawn_vec;
   logic                 w_taken;
   logic                 w_any_overlap;
   logic                 w_run_tick;
   logic                 w_freeze;
   logic                 w_spawn_now;
   logic [3:0]           w_exit_cnt;
   logic [16:0]          w_score_sum;
   logic [16:0]          w_level;
   logic [LANE_BITS-1:0] w_lane;
   logic [X_W-1:0]       w_spawn_x;

   // ---------------- game FSM ----------------
   always_ff @(posedge clk) begin
      if (BTNC) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_next;
      end
   end

   // An overlap in the same cycle as a tick suppresses that tick entirely.
   always_comb begin
      w_state_next = r_state;
      w_run_tick   = 1'b0;
      w_freeze     = 1'b0;
      case (r_state)
         RUN: begin
            if (w_any_overlap) begin
               w_state_next = CRASH;
            end else begin
               w_run_tick = tick;
            end
         end
         CRASH: begin
            w_freeze = 1'b1;
         end
         default: begin
            w_state_next = RUN;
         end
      endcase
   end

   // ---------------- spawn timer and free-slot picker ----------------
   always_comb begin
      w_spawn_cnt_next = r_spawn_cnt;
      w_spawn_now      = 1'b0;
      if (w_run_tick) begin
         if (r_spawn_cnt <= CNT_W'(1)) begin
            w_spawn_cnt_next = CNT_W'(SPAWN_GAP);
            w_spawn_now      = 1'b1;
         end else begin
            w_spawn_cnt_next = r_spawn_cnt - CNT_W'(1);
         end
      end
   end

   assign w_free = ~w_active | w_exit;

   always_comb begin
      w_spawn_vec = '0;
      w_taken     = 1'b0;
      for (int i = 0; i < N_RIVALS; i++) begin
         if (w_free[i] && !w_taken) begin
            w_spawn_vec[i] = w_spawn_now;
            w_taken        = 1'b1;
         end
      end
   end

   assign w_lane    = r_lfsr[LANE_BITS-1:0];
   assign w_spawn_x = X_W'(LANE_X0) + X_W'(LANE_PITCH) * X_W'(w_lane);

   // ---------------- score and speed ----------------
   always_comb begin
      w_exit_cnt = '0;
      for (int i = 0; i < N_RIVALS; i++) begin
         w_exit_cnt = w_exit_cnt + 4'(w_exit[i]);
      end
   end

   assign w_score_sum  = 17'(r_score) + 17'(w_exit_cnt);
   assign w_score_next = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
   assign w_level      = 17'(1) + 17'(w_score_next / 16'(LEVEL_PTS));
   assign w_speed_next = (w_level > 17'(SPEED_MAX)) ? 4'(SPEED_MAX) : w_level[3:0];

   always_ff @(posedge clk) begin
      if (BTNC) begin
         r_lfsr      <= LFSR_SEED;
         r_spawn_cnt <= CNT_W'(SPAWN_GAP);
         r_score     <= '0;
         r_speed     <= 4'd1;
      end else begin
         r_lfsr <= lfsr_next(r_lfsr);
         if (w_run_tick) begin
            r_spawn_cnt <= w_spawn_cnt_next;
            r_score     <= w_score_next;
            if (w_exit_cnt != 4'd0) begin
               r_speed <= w_speed_next;
            end
         end
      end
   end

   // ---------------- rival slots ----------------
   for (genvar g = 0; g < N_RIVALS; g++) begin : g_slot
      rival_slot #(
         .X_W      (X_W),
         .Y_W      (Y_W),
         .CAR_W    (CAR_W),
         .CAR_H    (CAR_H),
         .SCREEN_H (SCREEN_H)
      ) u_slot (
         .i_clk     (clk),
         .i_rst     (BTNC),
         .i_move    (w_run_tick),
         .i_freeze  (w_freeze),
         .i_spawn   (w_spawn_vec[g]),
         .i_spawn_x (w_spawn_x),
         .i_speed   (r_speed),
         .i_px      (car_x),
         .i_py      (car_y),
         .o_active  (w_active[g]),
         .o_x       (rival_x[g*X_W +: X_W]),
         .o_y       (rival_y[g*Y_W +: Y_W]),
         .o_exit    (w_exit[g]),
         .o_overlap (w_overlap[g])
      );
   end

   assign w_any_overlap = |w_overlap;

   assign rival_active = w_active;
   assign collision    = (r_state == CRASH);
   assign game_state   = r_state;
   assign score        = r_score;
   assign speed        = r_speed;

endmodule

// File: tb/tb_rival_fleet.sv
// Directed bench for rival_fleet with a fleet-level reference model checked every cycle.
module tb_rival_fleet;

   localparam int NR  = 4;
   localparam int XW  = 10;
   localparam int YW  = 10;
   localparam int GAP = 4;

   logic              clk  = 1'b0;
   logic              BTNC = 1'b1;
   logic              tick = 1'b0;
   logic [XW-1:0]     car_x = '0;
   logic [YW-1:0]     car_y = '0;
   logic [NR*XW-1:0]  rival_x;
   logic [NR*YW-1:0]  rival_y;
   logic [NR-1:0]     rival_active;
   logic              collision;
   logic [1:0]        game_state;
   logic [15:0]       score;
   logic [3:0]        speed;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int          m_act [NR];
   int          m_x   [NR];
   int          m_y   [NR];
   int          m_score;
   int          m_speed;
   int          m_cnt;
   bit          m_crash;
   logic [15:0] m_lfsr;
   bit          m_valid = 1'b0;
   int          snap_y [NR];

   always #5 clk = ~clk;

   rival_fleet #(
      .N_RIVALS  (NR),
      .N_LANES   (4),
      .X_W       (XW),
      .Y_W       (YW),
      .SPAWN_GAP (GAP)
   ) dut (
      .clk          (clk),
      .BTNC         (BTNC),
      .tick         (tick),
      .car_x        (car_x),
      .car_y        (car_y),
      .rival_x      (rival_x),
      .rival_y      (rival_y),
      .rival_active (rival_active),
      .collision    (collision),
      .game_state   (game_state),
      .score        (score),
      .speed        (speed)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: whole-fleet behaviour per clock edge, from the game rules.
   initial begin
      forever begin
         @(posedge clk);
         if (BTNC) begin
            for (int i = 0; i < NR; i++) begin
               m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
            end
            m_score = 0; m_speed = 1; m_cnt = GAP; m_crash = 1'b0;
            m_lfsr  = 16'hACE1;
            m_valid = 1'b1;
         end else if (m_valid) begin
            int hit;
            int px, py;
            px  = int'(car_x);
            py  = int'(car_y);
            hit = 0;
            for (int i = 0; i < NR; i++) begin
               if (m_act[i] != 0 && m_x[i] < px + 32 && px < m_x[i] + 32 &&
                   m_y[i] < py + 64 && py < m_y[i] + 64)
                  hit = 1;
            end
            if (!m_crash) begin
               if (hit != 0) begin
                  m_crash = 1'b1;
               end else if (tick) begin
                  int exits;
                  exits = 0;
                  for (int i = 0; i < NR; i++) begin
                     if (m_act[i] != 0) begin
                        if (m_y[i] + m_speed >= 480) begin
                           m_act[i] = 0; m_x[i] = 0; m_y[i] = 0;
                           exits++;
                        end else begin
                           m_y[i] = m_y[i] + m_speed;
                        end
                     end
                  end
                  if (exits > 0) begin
                     m_score = (m_score + exits > 65535) ? 65535 : m_score + exits;
                     m_speed = (1 + m_score / 8 > 8) ? 8 : 1 + m_score / 8;
                  end
                  m_cnt = m_cnt - 1;
                  if (m_cnt == 0) begin
                     int slot;
                     m_cnt = GAP;
                     slot  = -1;
                     for (int i = NR - 1; i >= 0; i--)
                        if (m_act[i] == 0) slot = i;
                     if (slot >= 0) begin
                        m_act[slot] = 1;
                        m_y[slot]   = 0;
                        m_x[slot]   = 160 + 80 * int'(m_lfsr[1:0]);
                     end
                  end
               end
            end
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
         end
      end
   end

   // Compare every cycle, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (m_valid) begin
            logic [NR-1:0] exp_act;
            chk("game_state", 32'(game_state), 32'(m_crash));
            chk("collision", 32'(collision), 32'(m_crash));
            chk("score", 32'(score), m_score);
            chk("speed", 32'(speed), m_speed);
            for (int i = 0; i < NR; i++) exp_act[i] = (m_act[i] != 0);
            chk("rival_active", 32'(rival_active), 32'(exp_act));
            for (int i = 0; i < NR; i++) begin
               if (m_act[i] != 0) begin
                  chk($sformatf("rival_x%0d", i), 32'(rival_x[i*XW +: XW]), m_x[i]);
                  chk($sformatf("rival_y%0d", i), 32'(rival_y[i*YW +: YW]), m_y[i]);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: time limit reached, got running, expected finished");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $fatal(1, "timeout");
   end

   task automatic cyc(input bit t);
      tick = t;
      @(negedge clk);
   endtask

   initial begin
      logic [XW-1:0] x0;
      // reset held for two edges
      @(negedge clk);
      @(negedge clk);
      chk("rst_active", 32'(rival_active), 32'd0);
      chk("rst_score", 32'(score), 32'd0);
      chk("rst_speed", 32'(speed), 32'd1);
      chk("rst_state", 32'(game_state), 32'd0);
      chk("rst_collision", 32'(collision), 32'd0);
      chk("rst_rival_x", 32'(rival_x), 32'd0);
      chk("rst_rival_y", 32'(rival_y), 32'd0);
      BTNC = 1'b0;

      // spawn cadence, ticks every 10 cycles
      for (int k = 1; k <= 8; k++) begin
         cyc(1'b1);
         if (k == 3) chk("spawn_none_yet", 32'(rival_active), 32'd0);
         if (k == 4) begin
            x0 = rival_x[XW-1:0];
            chk("spawn_slot0", 32'(rival_active), 32'd1);
            chk("spawn_y0", 32'(rival_y[YW-1:0]), 32'd0);
            chk("spawn_x_lane", 32'(x0 == 160 || x0 == 240 || x0 == 320 || x0 == 400), 32'd1);
         end
         if (k == 8) begin
            chk("spawn_slot1", 32'(rival_active), 32'd3);
            chk("slot0_y_after8", 32'(rival_y[YW-1:0]), 32'd4);
         end
         repeat (9) cyc(1'b0);
      end

      // exits, full-slot drops, speed level; player parked at x=0
      for (int t = 9; t <= 976; t++) begin
         cyc(1'b1);
         if (t == 20) begin
            chk("full_active", 32'(rival_active), 32'hF);
            chk("full_y0", 32'(rival_y[YW-1:0]), 32'd16);
         end
         if (t == 483) begin
            chk("pre_exit_score", 32'(score), 32'd0);
            chk("pre_exit_y0", 32'(rival_y[YW-1:0]), 32'd479);
         end
         if (t == 484) begin
            chk("exit_score", 32'(score), 32'd1);
            chk("respawn_active", 32'(rival_active), 32'hF);
            chk("respawn_y0", 32'(rival_y[YW-1:0]), 32'd0);
         end
         if (t == 975) begin
            chk("score7", 32'(score), 32'd7);
            chk("speed1", 32'(speed), 32'd1);
         end
         if (t == 976) begin
            chk("score8", 32'(score), 32'd8);
            chk("speed2", 32'(speed), 32'd2);
         end
      end

      // edge case: player exactly one car width left of slot 0, no overlap
      car_x = XW'(m_x[0] - 32);
      car_y = (m_y[0] >= 10) ? YW'(m_y[0] - 10) : '0;
      cyc(1'b0);
      cyc(1'b0);
      chk("edge_no_collision", 32'(collision), 32'd0);
      chk("edge_state_run", 32'(game_state), 32'd0);

      // overlap together with a tick: crash wins, nothing moves
      for (int i = 0; i < NR; i++) snap_y[i] = m_y[i];
      car_x = XW'(m_x[0]);
      cyc(1'b1);
      chk("crash_collision", 32'(collision), 32'd1);
      chk("crash_state", 32'(game_state), 32'd1);
      chk("crash_score", 32'(score), 32'd8);
      repeat (10) cyc(1'b1);
      chk("frozen_score", 32'(score), 32'd8);
      chk("frozen_speed", 32'(speed), 32'd2);
      for (int i = 0; i < NR; i++)
         chk($sformatf("frozen_y%0d", i), 32'(rival_y[i*YW +: YW]), snap_y[i]);

      // reset mid-crash with a tick present
      BTNC  = 1'b1;
      car_x = '0;
      car_y = '0;
      cyc(1'b1);
      BTNC = 1'b0;
      chk("midrst_state", 32'(game_state), 32'd0);
      chk("midrst_active", 32'(rival_active), 32'd0);
      chk("midrst_score", 32'(score), 32'd0);
      chk("midrst_speed", 32'(speed), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         cyc(1'b1);
         if (k == 3) chk("resume_none_yet", 32'(rival_active), 32'd0);
         if (k == 4) chk("resume_spawn", 32'(rival_active), 32'd1);
      end
      repeat (3) cyc(1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
